// File: rtl/spi_slave_param.sv
`default_nettype none
// spi_slave_param: clk-synchronous SPI-style slave with a 2-bit command prefix,
// a write/read-address/read-data protocol and a timed wait for the read payload.
module spi_slave_param #(
  parameter int DATA_W      = 8,
  parameter bit LSB_FIRST   = 1'b0,
  parameter int TX_WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int              CNT_W      = $clog2(DATA_W + 3);
  localparam logic [CNT_W-1:0] FRAME_BITS = CNT_W'(DATA_W + 2);
  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(DATA_W + 1);
  localparam logic [CNT_W-1:0] TX_BITS    = CNT_W'(DATA_W);
  localparam logic [7:0]       WAIT_MAX   = 8'(TX_WAIT_MAX);

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    CHK_CMD        = 3'd1,
    WRITE          = 3'd2,
    READ_ADD       = 3'd3,
    READ_DATA_RX   = 3'd4,
    READ_DATA_WAIT = 3'd5,
    READ_DATA_TX   = 3'd6
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  bit_cnt;
  logic [7:0]        wait_cnt;
  logic [DATA_W:0]   rx_sr;
  logic [DATA_W-1:0] tx_sr;
  logic              rd_addr_seen;

  logic              sample, complete, load_tx, tx_shift, tx_end;
  logic              wait_inc, wait_clr, err_n, rx_done;
  logic [DATA_W+1:0] frame_raw;
  logic [DATA_W-1:0] payload;
  logic              tx_bit;

  // Bits are captured in arrival order, so the first bit ends up at the MSB.
  assign frame_raw = {rx_sr, MOSI};
  assign rx_done   = (bit_cnt == FRAME_BITS);
  assign busy      = (state != IDLE);
  assign tx_bit    = LSB_FIRST ? tx_sr[0] : tx_sr[DATA_W-1];

  always_comb begin
    payload = frame_raw[DATA_W-1:0];
    if (LSB_FIRST) begin
      for (int i = 0; i < DATA_W; i++) begin
        payload[i] = frame_raw[DATA_W-1-i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    sample   = 1'b0;
    complete = 1'b0;
    load_tx  = 1'b0;
    tx_shift = 1'b0;
    tx_end   = 1'b0;
    wait_inc = 1'b0;
    wait_clr = 1'b0;
    err_n    = 1'b0;
    case (state)
      IDLE: begin
        if (!SS_n) state_n = CHK_CMD;
      end
      CHK_CMD: begin
        sample  = 1'b1;
        state_n = !MOSI ? WRITE : (rd_addr_seen ? READ_DATA_RX : READ_ADD);
      end
      WRITE, READ_ADD: begin
        if (!rx_done) begin
          sample   = 1'b1;
          complete = (bit_cnt == LAST_IDX);
        end
      end
      READ_DATA_RX: begin
        sample = 1'b1;
        if (bit_cnt == LAST_IDX) begin
          complete = 1'b1;
          wait_clr = 1'b1;
          state_n  = READ_DATA_WAIT;
        end
      end
      READ_DATA_WAIT: begin
        // A saturated wait counter marks a timed-out frame; it idles until SS_n rises.
        if (wait_cnt != WAIT_MAX) begin
          if (tx_valid) begin
            load_tx = 1'b1;
            state_n = READ_DATA_TX;
          end else begin
            wait_inc = 1'b1;
            err_n    = (wait_cnt == WAIT_MAX - 8'd1);
          end
        end
      end
      READ_DATA_TX: begin
        if (bit_cnt < TX_BITS)       tx_shift = 1'b1;
        else if (bit_cnt == TX_BITS) tx_end   = 1'b1;
      end
      default: state_n = IDLE;
    endcase

    if (state != IDLE && SS_n) begin
      state_n  = IDLE;
      sample   = 1'b0;
      complete = 1'b0;
      load_tx  = 1'b0;
      tx_shift = 1'b0;
      wait_inc = 1'b0;
      wait_clr = 1'b0;
      err_n    = (state == CHK_CMD) ||
                 ((state == WRITE || state == READ_ADD || state == READ_DATA_RX) && !rx_done) ||
                 (state == READ_DATA_TX && bit_cnt < TX_BITS);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt      <= '0;
      wait_cnt     <= '0;
      rx_sr        <= '0;
      tx_sr        <= '0;
      rd_addr_seen <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      frame_err    <= 1'b0;
      MISO         <= 1'b0;
    end else begin
      rx_valid  <= complete;
      frame_err <= err_n;
      MISO      <= tx_shift ? tx_bit : 1'b0;

      if (state == IDLE) bit_cnt <= '0;

      if (sample) begin
        rx_sr   <= frame_raw[DATA_W:0];
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (complete) begin
        rx_data <= {frame_raw[DATA_W+1:DATA_W], payload};
        if (state == READ_ADD) rd_addr_seen <= 1'b1;
      end

      if (wait_clr)      wait_cnt <= '0;
      else if (wait_inc) wait_cnt <= wait_cnt + 8'd1;

      // The bit counter is reused to count driven payload bits once the read data is loaded.
      if (load_tx) begin
        tx_sr   <= tx_data;
        bit_cnt <= '0;
      end else if (tx_shift) begin
        tx_sr   <= LSB_FIRST ? (tx_sr >> 1) : (tx_sr << 1);
        bit_cnt <= bit_cnt + 1'b1;
      end else if (tx_end) begin
        rd_addr_seen <= 1'b0;
        bit_cnt      <= bit_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_param.sv
`default_nettype none
// tb_spi_slave_param: MSB-first and LSB-first instances share one stimulus stream and
// are compared against a frame-level model (wire bits -> expected words / MISO bits).
module tb_spi_slave_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ss_n = 1'b1;
  logic       mosi = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;

  logic       miso_m, miso_l, rxv_m, rxv_l, fe_m, fe_l, busy_m, busy_l;
  logic [9:0] rxd_m, rxd_l;

  int total = 0;
  int bad   = 0;

  // Model state
  bit         seen = 1'b0;
  logic [9:0] last_m = 10'h0;
  logic [9:0] last_l = 10'h0;

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] pay;
    logic [9:0] exp_m;
    logic [9:0] exp_l;
  } vec_t;
  vec_t tbl [6];

  spi_slave_param #(.DATA_W(8), .LSB_FIRST(1'b0), .TX_WAIT_MAX(15)) u_msb (
    .clk(clk), .rst(rst), .SS_n(ss_n), .MOSI(mosi), .MISO(miso_m),
    .rx_data(rxd_m), .rx_valid(rxv_m), .tx_data(tx_data), .tx_valid(tx_valid),
    .frame_err(fe_m), .busy(busy_m)
  );

  spi_slave_param #(.DATA_W(8), .LSB_FIRST(1'b1), .TX_WAIT_MAX(15)) u_lsb (
    .clk(clk), .rst(rst), .SS_n(ss_n), .MOSI(mosi), .MISO(miso_l),
    .rx_data(rxd_l), .rx_valid(rxv_l), .tx_data(tx_data), .tx_valid(tx_valid),
    .frame_err(fe_l), .busy(busy_l)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_seen(input string nm);
    chk({nm, " seen_m"}, 32'(u_msb.rd_addr_seen), 32'(seen));
    chk({nm, " seen_l"}, 32'(u_lsb.rd_addr_seen), 32'(seen));
  endtask

  // Expected words from the wire-bit view: the LSB-first device reads the
  // payload bit at wire position 2+k as payload bit k.
  function automatic logic [9:0] exp_lsb(input logic [1:0] cmd, input logic [7:0] wire_pay);
    int v;
    v = 0;
    for (int k = 0; k < 8; k++) v += int'(wire_pay[7-k]) << k;
    return {cmd, 8'(v)};
  endfunction

  // Sends nbits of the frame {cmd, pay} (wire order, MSB of the 10-bit word first).
  task automatic frame(input logic [1:0] cmd, input logic [7:0] pay, input int nbits,
                       input logic [9:0] em, input logic [9:0] el);
    logic [9:0] w;
    w = {cmd, pay};
    ss_n = 1'b0;
    tick();
    chk("busy_chk", 32'(busy_m), 32'd1);
    for (int i = 0; i < nbits; i++) begin
      mosi = w[9-i];
      tick();
      if (i < 9) begin
        chk("rxv_early", 32'({rxv_m, rxv_l}), 32'd0);
        chk("busy_frame", 32'({busy_m, busy_l}), 32'd3);
      end
    end
    if (nbits == 10) begin
      chk("rxv_m", 32'(rxv_m), 32'd1);
      chk("rxv_l", 32'(rxv_l), 32'd1);
      chk("rxd_m", 32'(rxd_m), 32'(em));
      chk("rxd_l", 32'(rxd_l), 32'(el));
      last_m = em;
      last_l = el;
      if (cmd[1] && !seen) seen = 1'b1;
    end
  endtask

  // Trailing bits after a completed write/read-address frame must be ignored.
  task automatic finish_frame();
    tx_valid = 1'b1;
    mosi = 1'($urandom);
    tick();
    chk("rxv_once", 32'({rxv_m, rxv_l}), 32'd0);
    chk("miso_idle", 32'({miso_m, miso_l}), 32'd0);
    mosi = 1'($urandom);
    tick();
    tx_valid = 1'b0;
    ss_n = 1'b1;
    tick();
    chk("fe_clean", 32'({fe_m, fe_l}), 32'd0);
    chk("busy_idle", 32'({busy_m, busy_l}), 32'd0);
    chk("rxd_hold", 32'({rxd_m, rxd_l}), 32'({last_m, last_l}));
    chk_seen("after_frame");
  endtask

  task automatic abort_check(input string nm);
    ss_n = 1'b1;
    tick();
    chk({nm, " fe"}, 32'({fe_m, fe_l}), 32'd3);
    chk({nm, " rxv"}, 32'({rxv_m, rxv_l}), 32'd0);
    chk({nm, " rxd"}, 32'({rxd_m, rxd_l}), 32'({last_m, last_l}));
    chk({nm, " miso"}, 32'({miso_m, miso_l}), 32'd0);
    tick();
    chk({nm, " fe_pulse"}, 32'({fe_m, fe_l}), 32'd0);
    chk_seen(nm);
  endtask

  // Called right after a read-data frame's rx_valid cycle. abort_at=8 means no abort.
  task automatic do_tx(input int waitc, input logic [7:0] t, input int abort_at);
    for (int w = 0; w < waitc; w++) begin
      tick();
      chk("wait_miso", 32'({miso_m, miso_l}), 32'd0);
      chk("wait_fe", 32'({fe_m, fe_l}), 32'd0);
    end
    tx_valid = 1'b1;
    tx_data  = t;
    tick();
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    for (int k = 0; k < 8; k++) begin
      if (k == abort_at) begin
        abort_check("tx_abort");
        return;
      end
      tick();
      chk("miso_m", 32'(miso_m), 32'((t >> (7 - k)) & 8'd1));
      chk("miso_l", 32'(miso_l), 32'((t >> k) & 8'd1));
    end
    tick();
    chk("miso_end", 32'({miso_m, miso_l}), 32'd0);
    seen = 1'b0;
    ss_n = 1'b1;
    tick();
    chk("tx_fe", 32'({fe_m, fe_l}), 32'd0);
    chk("tx_busy", 32'({busy_m, busy_l}), 32'd0);
    chk_seen("after_tx");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{2'b00, 8'hA5, 10'h0A5, 10'h0A5};
    tbl[1] = '{2'b01, 8'hA5, 10'h1A5, 10'h1A5};
    tbl[2] = '{2'b00, 8'h01, 10'h001, 10'h080};
    tbl[3] = '{2'b01, 8'hF0, 10'h1F0, 10'h10F};
    tbl[4] = '{2'b00, 8'h3C, 10'h03C, 10'h03C};
    tbl[5] = '{2'b00, 8'hC8, 10'h0C8, 10'h013};

    // Reset state
    tick();
    tick();
    chk("rst_outs", 32'({miso_m, miso_l, rxv_m, rxv_l, fe_m, fe_l, busy_m, busy_l}), 32'd0);
    chk("rst_rxd", 32'({rxd_m, rxd_l}), 32'd0);
    chk_seen("rst");
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'({busy_m, busy_l}), 32'd0);

    // Table-driven write frames
    for (int i = 0; i < 6; i++) begin
      frame(tbl[i].cmd, tbl[i].pay, 10, tbl[i].exp_m, tbl[i].exp_l);
      finish_frame();
    end

    // Abort after 5 bits of a write frame, then a clean frame
    frame(2'b00, 8'h5A, 5, 10'h0, 10'h0);
    abort_check("wr_abort");
    frame(2'b00, 8'h96, 10, 10'h096, exp_lsb(2'b00, 8'h96));
    finish_frame();

    // Read address, read data, payload 0xB7 three cycles later
    frame(2'b10, 8'h3C, 10, 10'h23C, 10'h23C);
    finish_frame();
    frame(2'b11, 8'h00, 10, 10'h300, 10'h300);
    do_tx(3, 8'hB7, 8);

    // Read-data timeout, then the read-data frame is repeated and served
    frame(2'b10, 8'h11, 10, 10'h211, exp_lsb(2'b10, 8'h11));
    finish_frame();
    frame(2'b11, 8'h22, 10, 10'h322, exp_lsb(2'b11, 8'h22));
    for (int c = 1; c <= 15; c++) begin
      tick();
      chk("to_fe", 32'({fe_m, fe_l}), (c == 15) ? 32'd3 : 32'd0);
      chk("to_miso", 32'({miso_m, miso_l}), 32'd0);
    end
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    tick();
    tx_valid = 1'b0;
    chk("to_fe_once", 32'({fe_m, fe_l}), 32'd0);
    tick();
    chk("to_late_miso", 32'({miso_m, miso_l}), 32'd0);
    ss_n = 1'b1;
    tick();
    chk("to_exit_fe", 32'({fe_m, fe_l}), 32'd0);
    chk_seen("timeout");
    frame(2'b11, 8'h44, 10, 10'h344, exp_lsb(2'b11, 8'h44));
    do_tx(0, 8'h6D, 8);

    // Reset asserted between edges in the middle of READ_DATA_TX
    frame(2'b10, 8'h01, 10, 10'h201, exp_lsb(2'b10, 8'h01));
    finish_frame();
    frame(2'b11, 8'hE1, 10, 10'h3E1, exp_lsb(2'b11, 8'hE1));
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    tick();
    tx_valid = 1'b0;
    tick();
    tick();
    chk("pre_rst_miso", 32'(miso_m), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst", 32'({miso_m, miso_l, busy_m, busy_l, rxv_m, rxv_l, fe_m, fe_l}), 32'd0);
    ss_n = 1'b1;
    tick();
    chk("rst_no_fe", 32'({fe_m, fe_l}), 32'd0);
    seen = 1'b0;
    last_m = 10'h0;
    last_l = 10'h0;
    chk_seen("midtx_rst");
    rst = 1'b0;
    tick();
    frame(2'b01, 8'h0F, 10, 10'h10F, exp_lsb(2'b01, 8'h0F));
    finish_frame();

    // Randomized traffic against the model
    for (int n = 0; n < 40; n++) begin
      logic [1:0] cmd;
      logic [7:0] pay;
      bit         is_rd;
      cmd   = 2'($urandom);
      pay   = 8'($urandom);
      is_rd = cmd[1] && seen;
      if ($urandom_range(0, 7) == 0) begin
        frame(cmd, pay, int'($urandom_range(0, 9)), 10'h0, 10'h0);
        abort_check("rnd_abort");
      end else begin
        frame(cmd, pay, 10, {cmd, pay}, exp_lsb(cmd, pay));
        if (is_rd) do_tx(int'($urandom_range(0, 6)), 8'($urandom),
                         ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : 8);
        else finish_frame();
      end
      if (ss_n == 1'b0) begin
        ss_n = 1'b1;
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
